// File: rtl/cpu_pkg.sv
// Shared front-end definitions: issue kinds, the default injection word and a
// helper for occupancy-counter width.
package cpu_pkg;

    localparam logic [1:0] KIND_QUEUE  = 2'd0;
    localparam logic [1:0] KIND_REPLAY = 2'd1;
    localparam logic [1:0] KIND_TRAP   = 2'd2;
    localparam logic [1:0] KIND_INT    = 2'd3;

    localparam logic [63:0] INJ_WORD_DEF = 64'h0000_0000_0000_C0CD;

    typedef struct packed {
        logic       take;
        logic [1:0] kind;
    } issue_sel_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Circular instruction buffer; pointers wrap modulo DEPTH (a power of two).
module issue_fifo
    import cpu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      push,
    input  logic                      pop,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          head,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;

    always_ff @(posedge iClk) begin
        if (iRst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (push && !flush) mem[wptr] <= din;
    end

    assign head = mem[rptr];

endmodule

// File: rtl/inst_issue_queue.sv
// Instruction prefetch/issue queue: credit-based fetch requests, a circular
// buffer, and a per-slot pick among replay, trap, interrupt and queue head.
module inst_issue_queue
    import cpu_pkg::*;
#(
    parameter int               WIDTH    = 64,
    parameter int               DEPTH    = 8,
    parameter int               VEC_W    = 8,
    parameter logic [WIDTH-1:0] INJ_WORD = WIDTH'(INJ_WORD_DEF)
) (
    input  logic                    iClk,
    input  logic                    iRst,
    output logic                    oReq,
    input  logic                    iAck,
    input  logic [WIDTH-1:0]        iInst,
    input  logic                    iFlush,
    input  logic                    iReady,
    input  logic                    iHold,
    input  logic                    iPrefix,
    input  logic                    iRepArm,
    input  logic                    iTrap,
    input  logic                    iIntEn,
    input  logic                    iInt,
    input  logic [VEC_W-1:0]        iIntVec,
    input  logic                    iHalt,
    output logic                    oIssue,
    output logic [WIDTH-1:0]        oInst,
    output logic [1:0]              oKind,
    output logic [VEC_W-1:0]        oVec,
    output logic                    oIntAck,
    output logic                    oHalted,
    output logic [cnt_w(DEPTH)-1:0] oCount
);

    localparam int CW = cnt_w(DEPTH);

    logic [CW-1:0]    count, outstanding;
    logic [CW:0]      committed;
    logic [WIDTH-1:0] head, retire_q, word;
    logic [VEC_W-1:0] vec_q;
    logic             rep_pend, trap_pend, int_pend, shadow;
    logic             slot, pop, ack_ok, int_set;
    issue_sel_t       sel;

    issue_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .iClk  (iClk),
        .iRst  (iRst),
        .push  (iAck & ~iFlush),
        .pop   (pop),
        .flush (iFlush),
        .din   (iInst),
        .head  (head),
        .count (count)
    );

    assign oCount = count;

    // Injection waits out a prefix shadow so a prefix never loses its target.
    always_comb begin
        slot = iReady & ~iHold & ~iFlush;
        sel  = '{take: 1'b0, kind: KIND_QUEUE};
        if (slot) begin
            if (rep_pend)                 sel = '{take: 1'b1, kind: KIND_REPLAY};
            else if (trap_pend && !shadow) sel = '{take: 1'b1, kind: KIND_TRAP};
            else if (int_pend && !shadow)  sel = '{take: 1'b1, kind: KIND_INT};
            else if (count != '0 && !oHalted) sel = '{take: 1'b1, kind: KIND_QUEUE};
        end
        pop = sel.take && (sel.kind == KIND_QUEUE);
        case (sel.kind)
            KIND_QUEUE:  word = head;
            KIND_REPLAY: word = retire_q;
            default:     word = INJ_WORD;
        endcase
        committed = (CW+1)'(count) + (CW+1)'(outstanding) + (CW+1)'(oReq);
        ack_ok    = iAck && (outstanding != '0);
        int_set   = iInt && iIntEn && !int_pend && !oIntAck;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oReq        <= 1'b0;
            outstanding <= '0;
            oIssue      <= 1'b0;
            oInst       <= '0;
            oKind       <= KIND_QUEUE;
            oVec        <= '0;
            oIntAck     <= 1'b0;
            oHalted     <= 1'b0;
            retire_q    <= '0;
            vec_q       <= '0;
            rep_pend    <= 1'b0;
            trap_pend   <= 1'b0;
            int_pend    <= 1'b0;
            shadow      <= 1'b0;
        end else begin
            if (iAck && !iFlush) assert (count != CW'(DEPTH));
            oReq        <= !iFlush && (committed < (CW+1)'(DEPTH));
            outstanding <= iFlush ? '0 : outstanding + CW'(oReq) - CW'(ack_ok);
            oIssue      <= sel.take;
            oKind       <= sel.take ? sel.kind : KIND_QUEUE;
            oInst       <= sel.take ? word : '0;
            oVec        <= (sel.take && sel.kind == KIND_INT) ? vec_q : '0;
            oIntAck     <= sel.take && (sel.kind == KIND_INT);
            if (pop) retire_q <= head;

            if (iFlush)                                   rep_pend <= 1'b0;
            else if (iRepArm)                             rep_pend <= 1'b1;
            else if (sel.take && sel.kind == KIND_REPLAY) rep_pend <= 1'b0;

            if (iFlush)       shadow <= 1'b0;
            else if (iPrefix) shadow <= 1'b1;
            else if (pop)     shadow <= 1'b0;

            if (iTrap)                                  trap_pend <= 1'b1;
            else if (sel.take && sel.kind == KIND_TRAP) trap_pend <= 1'b0;

            if (int_set) begin
                int_pend <= 1'b1;
                vec_q    <= iIntVec;
            end else if (sel.take && sel.kind == KIND_INT) begin
                int_pend <= 1'b0;
            end

            // Injected traps and interrupts are the way out of HLT.
            if (iHalt)                        oHalted <= 1'b1;
            else if (sel.take && sel.kind[1]) oHalted <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue: credit fill/drain, flush, then a
// per-cycle vector table for replay, prefix shadow, trap/int and halt.
module tb_inst_issue_queue;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        oReq, iAck, iFlush, iReady, iHold, iPrefix, iRepArm;
    logic        iTrap, iIntEn, iInt, iHalt;
    logic [63:0] iInst;
    logic [7:0]  iIntVec;
    logic        oIssue, oIntAck, oHalted;
    logic [63:0] oInst;
    logic [1:0]  oKind;
    logic [7:0]  oVec;
    logic [3:0]  oCount;

    inst_issue_queue dut (
        .iClk(iClk), .iRst(iRst), .oReq(oReq), .iAck(iAck), .iInst(iInst),
        .iFlush(iFlush), .iReady(iReady), .iHold(iHold), .iPrefix(iPrefix),
        .iRepArm(iRepArm), .iTrap(iTrap), .iIntEn(iIntEn), .iInt(iInt),
        .iIntVec(iIntVec), .iHalt(iHalt), .oIssue(oIssue), .oInst(oInst),
        .oKind(oKind), .oVec(oVec), .oIntAck(oIntAck), .oHalted(oHalted),
        .oCount(oCount)
    );

    always #5 iClk = ~iClk;

    localparam logic [7:0] RDY = 8'h01, PRE = 8'h02, REP = 8'h04, TRP = 8'h08;
    localparam logic [7:0] INT = 8'h10, EN  = 8'h20, HLT = 8'h40, HLD = 8'h80;
    localparam logic [63:0] J  = 64'h0000_0000_0000_C0CD;

    typedef struct {
        logic [7:0]  ctl;
        logic        ack;
        logic [63:0] inst;
        logic [7:0]  vec;
        logic        e_iss;
        logic [1:0]  e_kind;
        logic [63:0] e_inst;
        logic [7:0]  e_vec;
        logic        e_ack;
        logic        e_halt;
        logic [3:0]  e_cnt;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] ctl, input logic ack, input logic [63:0] inst,
                                input logic [7:0] vec, input logic e_iss, input logic [1:0] e_kind,
                                input logic [63:0] e_inst, input logic [7:0] e_vec, input logic e_ack,
                                input logic e_halt, input logic [3:0] e_cnt);
        vec_t v;
        v.ctl = ctl; v.ack = ack; v.inst = inst; v.vec = vec;
        v.e_iss = e_iss; v.e_kind = e_kind; v.e_inst = e_inst; v.e_vec = e_vec;
        v.e_ack = e_ack; v.e_halt = e_halt; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic idle();
        iAck = 0; iInst = '0; iFlush = 0; iReady = 0; iHold = 0; iPrefix = 0;
        iRepArm = 0; iTrap = 0; iIntEn = 0; iInt = 0; iIntVec = '0; iHalt = 0;
    endtask

    task automatic tick();
        @(posedge iClk); #1;
    endtask

    task automatic apply(input vec_t v);
        iReady = v.ctl[0]; iPrefix = v.ctl[1]; iRepArm = v.ctl[2]; iTrap = v.ctl[3];
        iInt   = v.ctl[4]; iIntEn  = v.ctl[5]; iHalt   = v.ctl[6]; iHold = v.ctl[7];
        iAck = v.ack; iInst = v.inst; iIntVec = v.vec; iFlush = 0;
        tick();
    endtask

    vec_t        tab[$];
    logic [63:0] exp_q[$];
    logic [63:0] w;
    logic        req_prev, saw_req;
    int          nreq, word_n;

    initial begin
        idle();
        tick(); tick();
        chk("rst_oReq", oReq, 0);
        chk("rst_oIssue", oIssue, 0);
        chk("rst_oCount", oCount, 0);
        chk("rst_oHalted", oHalted, 0);
        chk("rst_oIntAck", oIntAck, 0);
        chk("rst_out", {oInst[7:0], oKind, oVec}, 0);
        iRst = 0;

        // Fill with iReady low: each request acked one cycle later.
        req_prev = 0; nreq = 0; word_n = 0;
        for (int c = 0; c < 20; c++) begin
            iAck = req_prev;
            if (req_prev) begin
                iInst = 64'h1000 + 64'(word_n);
                exp_q.push_back(iInst);
                word_n++;
            end
            req_prev = oReq;
            if (oReq) nreq++;
            tick();
        end
        chk("fill_nreq", 64'(nreq), 8);
        chk("fill_count", oCount, 8);
        chk("fill_oReq", oReq, 0);

        // Drain: eight consecutive kind-0 issues in fetch order.
        iReady = 1; saw_req = 0;
        for (int c = 0; c < 8; c++) begin
            iAck = req_prev;
            if (req_prev) begin
                iInst = 64'h1000 + 64'(word_n);
                exp_q.push_back(iInst);
                word_n++;
            end
            req_prev = oReq;
            tick();
            w = exp_q.pop_front();
            chk("drain_issue", oIssue, 1);
            chk("drain_kind", oKind, 0);
            chk("drain_inst", oInst, w);
            if (oReq) saw_req = 1;
        end
        chk("drain_req_back", saw_req, 1);

        idle(); iFlush = 1; tick(); idle();
        exp_q.delete();
        chk("cleanup_count", oCount, 0);
        tick(); tick();

        // Flush with a same-cycle ack drops everything.
        for (int c = 0; c < 3; c++) begin
            iAck = 1; iInst = 64'h2000 + 64'(c); tick();
        end
        chk("flush_pre_count", oCount, 3);
        iAck = 1; iInst = 64'hDEAD; iFlush = 1; iReady = 1; tick();
        chk("flush_count", oCount, 0);
        chk("flush_issue", oIssue, 0);
        chk("flush_oReq", oReq, 0);
        iAck = 0; iFlush = 0; tick();
        chk("flush_noissue", oIssue, 0);
        chk("flush_count2", oCount, 0);

        // Replay twice, then head.
        tab.push_back(mk(0,        1, 64'hA0, 0,     0, 0, 0,      0,     0, 0, 1));
        tab.push_back(mk(0,        1, 64'hB0, 0,     0, 0, 0,      0,     0, 0, 2));
        tab.push_back(mk(RDY,      0, 0,      0,     1, 0, 64'hA0, 0,     0, 0, 1));
        tab.push_back(mk(REP,      0, 0,      0,     0, 0, 0,      0,     0, 0, 1));
        tab.push_back(mk(RDY,      0, 0,      0,     1, 1, 64'hA0, 0,     0, 0, 1));
        tab.push_back(mk(REP,      0, 0,      0,     0, 0, 0,      0,     0, 0, 1));
        tab.push_back(mk(RDY,      0, 0,      0,     1, 1, 64'hA0, 0,     0, 0, 1));
        tab.push_back(mk(RDY,      0, 0,      0,     1, 0, 64'hB0, 0,     0, 0, 0));
        tab.push_back(mk(RDY,      0, 0,      0,     0, 0, 0,      0,     0, 0, 0));
        // Prefix shadow defers a pending interrupt past the prefixed target.
        tab.push_back(mk(0,        1, 64'hC1, 0,     0, 0, 0,      0,     0, 0, 1));
        tab.push_back(mk(0,        1, 64'hC2, 0,     0, 0, 0,      0,     0, 0, 2));
        tab.push_back(mk(RDY,      0, 0,      0,     1, 0, 64'hC1, 0,     0, 0, 1));
        tab.push_back(mk(PRE|INT|EN, 0, 0,   8'h21, 0, 0, 0,      0,     0, 0, 1));
        tab.push_back(mk(RDY|INT|EN, 0, 0,   8'h21, 1, 0, 64'hC2, 0,     0, 0, 0));
        tab.push_back(mk(RDY|EN,   0, 0,      0,     1, 3, J,      8'h21, 1, 0, 0));
        tab.push_back(mk(RDY|EN,   0, 0,      0,     0, 0, 0,      0,     0, 0, 0));
        // Trap beats interrupt.
        tab.push_back(mk(TRP|INT|EN, 0, 0,   8'h5A, 0, 0, 0,      0,     0, 0, 0));
        tab.push_back(mk(RDY|EN,   0, 0,      0,     1, 2, J,      0,     0, 0, 0));
        tab.push_back(mk(RDY|EN,   0, 0,      0,     1, 3, J,      8'h5A, 1, 0, 0));
        tab.push_back(mk(RDY|EN,   0, 0,      0,     0, 0, 0,      0,     0, 0, 0));
        // Hold blocks the slot.
        tab.push_back(mk(0,        1, 64'hD0, 0,     0, 0, 0,      0,     0, 0, 1));
        tab.push_back(mk(RDY|HLD,  0, 0,      0,     0, 0, 0,      0,     0, 0, 1));
        tab.push_back(mk(RDY,      0, 0,      0,     1, 0, 64'hD0, 0,     0, 0, 0));
        // Halt with four queued; interrupt wakes it.
        for (int i = 0; i < 4; i++)
            tab.push_back(mk(0, 1, 64'hE0 + 64'(i), 0, 0, 0, 0, 0, 0, 0, 4'(i + 1)));
        tab.push_back(mk(HLT,      0, 0,      0,     0, 0, 0,      0,     0, 1, 4));
        tab.push_back(mk(RDY,      0, 0,      0,     0, 0, 0,      0,     0, 1, 4));
        tab.push_back(mk(RDY,      0, 0,      0,     0, 0, 0,      0,     0, 1, 4));
        tab.push_back(mk(RDY|INT|EN, 0, 0,   8'h33, 0, 0, 0,      0,     0, 1, 4));
        tab.push_back(mk(RDY|EN,   0, 0,      0,     1, 3, J,      8'h33, 1, 0, 4));
        tab.push_back(mk(RDY,      0, 0,      0,     1, 0, 64'hE0, 0,     0, 0, 3));
        tab.push_back(mk(RDY,      0, 0,      0,     1, 0, 64'hE1, 0,     0, 0, 2));
        tab.push_back(mk(RDY|INT,  0, 0,      8'h44, 1, 0, 64'hE2, 0,     0, 0, 1));
        tab.push_back(mk(RDY|EN,   0, 0,      0,     1, 0, 64'hE3, 0,     0, 0, 0));
        tab.push_back(mk(RDY|EN,   0, 0,      0,     0, 0, 0,      0,     0, 0, 0));

        foreach (tab[i]) begin
            apply(tab[i]);
            chk($sformatf("v%0d_issue", i), oIssue, tab[i].e_iss);
            if (tab[i].e_iss) begin
                chk($sformatf("v%0d_kind", i), oKind, tab[i].e_kind);
                chk($sformatf("v%0d_inst", i), oInst, tab[i].e_inst);
                chk($sformatf("v%0d_vec", i), oVec, tab[i].e_vec);
            end
            chk($sformatf("v%0d_intack", i), oIntAck, tab[i].e_ack);
            chk($sformatf("v%0d_halted", i), oHalted, tab[i].e_halt);
            chk($sformatf("v%0d_count", i), oCount, tab[i].e_cnt);
        end

        // Mid-run reset clears queue, halt and the pending trap.
        idle(); iAck = 1; iInst = 64'hF0; iHalt = 1; iTrap = 1; tick();
        chk("mrst_pre_count", oCount, 1);
        chk("mrst_pre_halt", oHalted, 1);
        idle(); iRst = 1; tick();
        chk("mrst_count", oCount, 0);
        chk("mrst_halt", oHalted, 0);
        chk("mrst_oReq", oReq, 0);
        chk("mrst_issue", oIssue, 0);
        iRst = 0; iReady = 1; tick();
        chk("mrst_no_trap", oIssue, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
